// File: rtl/rggen_apb_requester.sv
// rtl/rggen_apb_requester.sv - APB4 requester turning a valid/ready command into single APB transfers
module rggen_apb_requester #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]   i_req_address,
  input  logic [BUS_WIDTH-1:0]       i_req_data,
  input  logic [BUS_WIDTH/8-1:0]     i_req_strobe,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [BUS_WIDTH-1:0]       o_rsp_data,
  output logic                       o_rsp_error,
  output logic                       o_rsp_timeout,
  output logic                       o_psel,
  output logic                       o_penable,
  output logic                       o_pwrite,
  output logic [ADDRESS_WIDTH-1:0]   o_paddr,
  output logic [BUS_WIDTH-1:0]       o_pwdata,
  output logic [BUS_WIDTH/8-1:0]     o_pstrb,
  output logic [2:0]                 o_pprot,
  input  logic                       i_pready,
  input  logic                       i_pslverr,
  input  logic [BUS_WIDTH-1:0]       i_prdata
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
    ~ADDRESS_WIDTH'((1 << ADDR_LSB) - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETUP    = 2'd1;
  localparam logic [1:0] ACCESS   = 2'd2;
  localparam logic [1:0] RESPONSE = 2'd3;

  logic [1:0]               state;
  logic [CNT_WIDTH-1:0]     wait_count;
  logic                     cmd_write;
  logic [ADDRESS_WIDTH-1:0] cmd_address;
  logic [BUS_WIDTH-1:0]     cmd_data;
  logic [STRB_WIDTH-1:0]    cmd_strobe;
  logic [BUS_WIDTH-1:0]     rsp_data;
  logic                     rsp_error;
  logic                     rsp_timeout;
  logic                     in_transfer;
  logic                     timeout_hit;

  // A late i_pready still wins because timeout_hit is qualified by !i_pready.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_count == CNT_LAST) && !i_pready;
  assign in_transfer = (state == SETUP) || (state == ACCESS);

  // Transfer sequencing: command latch, wait counting and response capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      wait_count  <= '0;
      cmd_write   <= 1'b0;
      cmd_address <= '0;
      cmd_data    <= '0;
      cmd_strobe  <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            // Read commands carry no write data or strobes onto the bus.
            cmd_write   <= i_req_write;
            cmd_address <= i_req_address & ADDR_MASK;
            cmd_data    <= i_req_write ? i_req_data : '0;
            cmd_strobe  <= i_req_write ? i_req_strobe : '0;
            wait_count  <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (i_pready) begin
            rsp_error   <= i_pslverr;
            rsp_data    <= (!cmd_write && !i_pslverr) ? i_prdata : '0;
            rsp_timeout <= 1'b0;
            state       <= RESPONSE;
          end else if (timeout_hit) begin
            rsp_error   <= 1'b1;
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            state       <= RESPONSE;
          end else if (wait_count != {CNT_WIDTH{1'b1}}) begin
            wait_count <= wait_count + CNT_WIDTH'(1);
          end
        end
        RESPONSE: begin
          if (i_rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus and response outputs decode from state so they are zero whenever not meaningful.
  always_comb begin
    o_req_ready   = (state == IDLE);
    o_psel        = in_transfer;
    o_penable     = (state == ACCESS);
    o_pwrite      = in_transfer & cmd_write;
    o_paddr       = in_transfer ? cmd_address : '0;
    o_pwdata      = in_transfer ? cmd_data : '0;
    o_pstrb       = in_transfer ? cmd_strobe : '0;
    o_pprot       = 3'b000;
    o_rsp_valid   = (state == RESPONSE);
    o_rsp_data    = (state == RESPONSE) ? rsp_data : '0;
    o_rsp_error   = (state == RESPONSE) & rsp_error;
    o_rsp_timeout = (state == RESPONSE) & rsp_timeout;
  end
endmodule
